// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an internal
// instruction register, a persistent compare flag, memory wait counter and retire counter.
module multicycle_control #(
  parameter int unsigned     ALUW     = 4,
  parameter logic [ALUW-1:0] ALU_PASS = '1,
  parameter int unsigned     MEM_LAT  = 1,
  parameter int unsigned     CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [3:0]      instr,
  input  logic            equal,
  output logic            ir_load,
  output logic            pc_en,
  output logic            Branch,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic [ALUW-1:0] ALUOp,
  output logic            flag_eq,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] instr_count
);

  localparam int unsigned OPW   = 4;
  localparam int unsigned WAITW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [OPW-1:0] OP_AND  = 4'b0110;
  localparam logic [OPW-1:0] OP_SLL  = 4'b0001;
  localparam logic [OPW-1:0] OP_SLR  = 4'b0010;
  localparam logic [OPW-1:0] OP_ADDI = 4'b0111;
  localparam logic [OPW-1:0] OP_BNE  = 4'b1000;
  localparam logic [OPW-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OPW-1:0] OP_MOVI = 4'b1010;
  localparam logic [OPW-1:0] OP_SW   = 4'b1011;
  localparam logic [OPW-1:0] OP_LW   = 4'b1100;
  localparam logic [OPW-1:0] OP_CMP  = 4'b1101;
  localparam logic [OPW-1:0] OP_NOP  = 4'b1110;
  localparam logic [OPW-1:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          r_state,   w_state_nxt;
  logic [OPW-1:0]  r_ir_op,   w_ir_nxt;
  logic            r_flag_eq, w_flag_nxt;
  logic [WAITW-1:0] r_wait,   w_wait_nxt;
  logic [CNTW-1:0] r_count;

  logic            r_ir_load,  w_ir_load;
  logic            r_pc_en,    w_pc_en;
  logic            r_branch,   w_branch;
  logic            r_regdst,   w_regdst;
  logic            r_alusrc,   w_alusrc;
  logic            r_regwrite, w_regwrite;
  logic            r_memwrite, w_memwrite;
  logic            r_memtoreg, w_memtoreg;
  logic [ALUW-1:0] r_aluop,    w_aluop;
  logic            r_busy,     w_busy;
  logic            r_done,     w_done;
  logic            w_decoded;

  // Next-state, instruction register, compare flag and memory wait counter
  always_comb begin
    w_state_nxt = r_state;
    w_ir_nxt    = r_ir_op;
    w_flag_nxt  = r_flag_eq;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_ir_nxt    = instr;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        case (r_ir_op)
          OP_CMP: begin
            w_flag_nxt  = equal;
            w_state_nxt = S_FETCH;
          end
          OP_BEQ, OP_BNE, OP_NOP: w_state_nxt = S_FETCH;
          OP_HALT:                w_state_nxt = S_HALT;
          OP_LW, OP_SW: begin
            w_wait_nxt  = WAITW'(MEM_LAT - 1);
            w_state_nxt = S_MEM;
          end
          default:                w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (r_wait == '0) begin
          w_state_nxt = (r_ir_op == OP_SW) ? S_FETCH : S_WB;
        end else begin
          w_wait_nxt = r_wait - WAITW'(1);
        end
      end
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   if (!start) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without a cycle of lag
  always_comb begin
    w_ir_load  = 1'b0;
    w_pc_en    = 1'b0;
    w_branch   = 1'b0;
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_aluop    = ALU_PASS;
    w_busy     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
    w_done     = (w_state_nxt == S_HALT);
    w_decoded  = (w_state_nxt == S_DECODE) || (w_state_nxt == S_EXEC) ||
                 (w_state_nxt == S_MEM)    || (w_state_nxt == S_WB);
    if (w_decoded) begin
      if ((w_ir_nxt <= OP_MOVI) || (w_ir_nxt == OP_CMP)) w_aluop = ALUW'(w_ir_nxt);
      w_alusrc = w_ir_nxt inside {OP_SLL, OP_SLR, OP_ADDI, OP_MOVI, OP_SW, OP_LW};
      w_regdst = (w_ir_nxt <= OP_AND);
    end
    case (w_state_nxt)
      S_FETCH: w_ir_load = 1'b1;
      S_EXEC: begin
        case (w_ir_nxt)
          OP_BEQ: begin
            w_pc_en  = 1'b1;
            w_branch = w_flag_nxt;
          end
          OP_BNE: begin
            w_pc_en  = 1'b1;
            w_branch = ~w_flag_nxt;
          end
          OP_CMP, OP_NOP: w_pc_en = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        w_memtoreg = (w_ir_nxt == OP_LW);
        if ((w_wait_nxt == '0) && (w_ir_nxt == OP_SW)) begin
          w_memwrite = 1'b1;
          w_pc_en    = 1'b1;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_pc_en    = 1'b1;
        w_memtoreg = (w_ir_nxt == OP_LW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ir_op    <= '0;
      r_flag_eq  <= 1'b0;
      r_wait     <= '0;
      r_count    <= '0;
      r_ir_load  <= 1'b0;
      r_pc_en    <= 1'b0;
      r_branch   <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_aluop    <= ALU_PASS;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir_op    <= w_ir_nxt;
      r_flag_eq  <= w_flag_nxt;
      r_wait     <= w_wait_nxt;
      // Saturating retire counter, stepped at the end of each pc_en cycle
      if (r_pc_en && (r_count != '1)) r_count <= r_count + CNTW'(1);
      r_ir_load  <= w_ir_load;
      r_pc_en    <= w_pc_en;
      r_branch   <= w_branch;
      r_regdst   <= w_regdst;
      r_alusrc   <= w_alusrc;
      r_regwrite <= w_regwrite;
      r_memwrite <= w_memwrite;
      r_memtoreg <= w_memtoreg;
      r_aluop    <= w_aluop;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign ir_load     = r_ir_load;
  assign pc_en       = r_pc_en;
  assign Branch      = r_branch;
  assign RegDst      = r_regdst;
  assign ALUSrc      = r_alusrc;
  assign RegWrite    = r_regwrite;
  assign MemWrite    = r_memwrite;
  assign MemtoReg    = r_memtoreg;
  assign ALUOp       = r_aluop;
  assign flag_eq     = r_flag_eq;
  assign busy        = r_busy;
  assign done        = r_done;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected output vectors are queued
// as each instruction is issued and popped against the DUT every cycle.
module tb_multicycle_control;

  localparam int unsigned ALUW    = 4;
  localparam int unsigned MEM_LAT = 3;
  localparam logic [3:0]  PASS    = 4'hF;

  localparam logic [3:0] ADD = 4'h0, SLL = 4'h1, MOV = 4'h3, OR_ = 4'h4, ADDI = 4'h7;
  localparam logic [3:0] BNE = 4'h8, BEQ = 4'h9, MOVI = 4'hA, SW = 4'hB, LW = 4'hC;
  localparam logic [3:0] CMP = 4'hD, NOP = 4'hE, HALT = 4'hF;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       branch;
    logic       regdst;
    logic       alusrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [3:0] aluop;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, equal;
  logic [3:0] instr;

  logic            d1_ir_load, d1_pc_en, d1_branch, d1_regdst, d1_alusrc;
  logic            d1_regwrite, d1_memwrite, d1_memtoreg, d1_flag_eq, d1_busy, d1_done;
  logic [ALUW-1:0] d1_aluop;
  logic [15:0]     d1_count;

  logic            d2_ir_load, d2_pc_en, d2_branch, d2_regdst, d2_alusrc;
  logic            d2_regwrite, d2_memwrite, d2_memtoreg, d2_flag_eq, d2_busy, d2_done;
  logic [ALUW-1:0] d2_aluop;
  logic [1:0]      d2_count;

  multicycle_control #(.ALUW(ALUW), .ALU_PASS(PASS), .MEM_LAT(MEM_LAT), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .equal(equal),
    .ir_load(d1_ir_load), .pc_en(d1_pc_en), .Branch(d1_branch), .RegDst(d1_regdst),
    .ALUSrc(d1_alusrc), .RegWrite(d1_regwrite), .MemWrite(d1_memwrite),
    .MemtoReg(d1_memtoreg), .ALUOp(d1_aluop), .flag_eq(d1_flag_eq), .busy(d1_busy),
    .done(d1_done), .instr_count(d1_count)
  );

  multicycle_control #(.ALUW(ALUW), .ALU_PASS(PASS), .MEM_LAT(1), .CNTW(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .equal(equal),
    .ir_load(d2_ir_load), .pc_en(d2_pc_en), .Branch(d2_branch), .RegDst(d2_regdst),
    .ALUSrc(d2_alusrc), .RegWrite(d2_regwrite), .MemWrite(d2_memwrite),
    .MemtoReg(d2_memtoreg), .ALUOp(d2_aluop), .flag_eq(d2_flag_eq), .busy(d2_busy),
    .done(d2_done), .instr_count(d2_count)
  );

  int         checks   = 0;
  int         failures = 0;
  obs_t       exp_q[$];
  logic [3:0] prog_q[$];
  logic       model_flag;
  int         model_count;

  obs_t idle_v, halt_v;

  function automatic obs_t sample();
    obs_t o;
    o.ir_load  = d1_ir_load;
    o.pc_en    = d1_pc_en;
    o.branch   = d1_branch;
    o.regdst   = d1_regdst;
    o.alusrc   = d1_alusrc;
    o.regwrite = d1_regwrite;
    o.memwrite = d1_memwrite;
    o.memtoreg = d1_memtoreg;
    o.aluop    = d1_aluop;
    o.busy     = d1_busy;
    o.done     = d1_done;
    return o;
  endfunction

  // Queue the per-cycle outputs an instruction must produce, from opcode and stored flag
  function automatic void push_instr(input logic [3:0] op);
    obs_t s, e;
    s = '0;
    s.busy   = 1'b1;
    s.aluop  = ((op <= MOVI) || (op == CMP)) ? op : PASS;
    s.alusrc = op inside {4'h1, 4'h2, 4'h7, 4'hA, 4'hB, 4'hC};
    s.regdst = (op <= 4'h6);
    e = '0;
    e.busy = 1'b1;
    e.aluop = PASS;
    e.ir_load = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(s);
    e = s;
    case (op)
      CMP: e.pc_en = 1'b1;
      NOP: e.pc_en = 1'b1;
      BEQ: begin e.pc_en = 1'b1; e.branch = model_flag; end
      BNE: begin e.pc_en = 1'b1; e.branch = ~model_flag; end
      default: ;
    endcase
    exp_q.push_back(e);
    if (op == CMP) model_flag = equal;
    if (op == LW || op == SW) begin
      for (int k = 0; k < int'(MEM_LAT); k++) begin
        e = s;
        e.memtoreg = (op == LW);
        if (k == int'(MEM_LAT) - 1 && op == SW) begin
          e.memwrite = 1'b1;
          e.pc_en    = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
    if (!(op inside {CMP, NOP, BEQ, BNE, HALT, SW})) begin
      e = s;
      e.regwrite = 1'b1;
      e.pc_en    = 1'b1;
      e.memtoreg = (op == LW);
      exp_q.push_back(e);
    end
    if (op != HALT) model_count++;
    prog_q.push_back(op);
  endfunction

  // One cycle: sample at negedge, then act as instruction ROM if a fetch is in progress
  task automatic step(output obs_t o);
    @(negedge clk);
    o = sample();
    if (d1_ir_load) instr = (prog_q.size() > 0) ? prog_q.pop_front() : NOP;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    instr   = NOP;
    exp_q.delete();
    prog_q.delete();
    model_flag  = 1'b0;
    model_count = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic kick(input logic hold);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    o = sample();
    checks++;
    if (o !== idle_v) begin failures++; $display("FAIL reset_outputs: got %b expected %b", o, idle_v); end
    checks++;
    if (d1_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", d1_count); end
    checks++;
    if (d1_flag_eq !== 1'b0) begin failures++; $display("FAIL reset_flag: got %b expected 0", d1_flag_eq); end
  endtask

  task automatic test_alu();
    obs_t o, e;
    int n = 0;
    do_reset();
    equal = 1'b0;
    push_instr(ADD); push_instr(SLL); push_instr(ADDI); push_instr(MOVI);
    push_instr(OR_); push_instr(MOV);
    kick(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL alu cycle %0d: got %b expected %b", n, o, e); end
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (d1_count !== 16'(model_count)) begin
      failures++; $display("FAIL alu_count: got %0d expected %0d", d1_count, model_count);
    end
  endtask

  task automatic test_branch();
    obs_t o, e;
    int n = 0;
    do_reset();
    equal = 1'b1;
    push_instr(BEQ); push_instr(BNE);
    push_instr(CMP); push_instr(BNE); push_instr(BEQ); push_instr(NOP);
    kick(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL branch cycle %0d: got %b expected %b", n, o, e); end
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (d1_flag_eq !== 1'b1) begin failures++; $display("FAIL branch_flag: got %b expected 1", d1_flag_eq); end
    checks++;
    if (d1_count !== 16'(model_count)) begin
      failures++; $display("FAIL branch_count: got %0d expected %0d", d1_count, model_count);
    end
  endtask

  task automatic test_mem();
    obs_t o, e;
    int n = 0;
    do_reset();
    equal = 1'b0;
    push_instr(SW); push_instr(LW); push_instr(SW); push_instr(ADD);
    kick(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL mem cycle %0d: got %b expected %b", n, o, e); end
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (d1_count !== 16'(model_count)) begin
      failures++; $display("FAIL mem_count: got %0d expected %0d", d1_count, model_count);
    end
  endtask

  task automatic test_halt();
    obs_t o, e;
    int n = 0;
    do_reset();
    equal = 1'b0;
    push_instr(ADD); push_instr(HALT);
    repeat (3) exp_q.push_back(halt_v);
    kick(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL halt cycle %0d: got %b expected %b", n, o, e); end
      n++;
    end
    checks++;
    if (d1_count !== 16'(model_count)) begin
      failures++; $display("FAIL halt_count: got %0d expected %0d", d1_count, model_count);
    end
    start = 1'b0;
    step(o);
    checks++;
    if (o !== idle_v) begin failures++; $display("FAIL halt_release: got %b expected %b", o, idle_v); end
    step(o);
    checks++;
    if (o !== idle_v) begin failures++; $display("FAIL halt_idle_stay: got %b expected %b", o, idle_v); end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o, e;
    do_reset();
    equal = 1'b1;
    push_instr(CMP); push_instr(LW);
    kick(1'b0);
    for (int n = 0; n < 7; n++) begin
      e = exp_q.pop_front();
      step(o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL midrst cycle %0d: got %b expected %b", n, o, e); end
    end
    exp_q.delete();
    checks++;
    if (d1_memtoreg !== 1'b1 || d1_flag_eq !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: got memtoreg=%b flag=%b expected 1 1", d1_memtoreg, d1_flag_eq);
    end
    #2 reset_n = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== idle_v) begin failures++; $display("FAIL midrst_outputs: got %b expected %b", o, idle_v); end
    checks++;
    if (d1_flag_eq !== 1'b0 || d1_count !== 16'd0) begin
      failures++; $display("FAIL midrst_state: got flag=%b count=%0d expected 0 0", d1_flag_eq, d1_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step(o);
      checks++;
      if (o !== idle_v) begin failures++; $display("FAIL midrst_idle %0d: got %b expected %b", n, o, idle_v); end
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    int   exp_sat;
    do_reset();
    equal = 1'b0;
    for (int i = 0; i < 6; i++) prog_q.push_back(NOP);
    kick(1'b0);
    for (int i = 0; i < 6; i++) begin
      repeat (3) step(o);
      @(posedge clk); #1;
      exp_sat = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if (d2_count !== 2'(exp_sat)) begin
        failures++; $display("FAIL sat_count nop %0d: got %0d expected %0d", i, d2_count, exp_sat);
      end
      checks++;
      if (d1_count !== 16'(i + 1)) begin
        failures++; $display("FAIL wide_count nop %0d: got %0d expected %0d", i, d1_count, i + 1);
      end
    end
  endtask

  initial begin
    idle_v = '0;
    idle_v.aluop = PASS;
    halt_v = idle_v;
    halt_v.done = 1'b1;
    equal = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_halt();
    test_reset_mid_mem();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle control decoder.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and latches the opcode in an internal instruction register.
- Captures the ALU equality result from CMP in a persistent flag, which later BEQ/BNE read. This decouples compare from branch.
- Adds a parametrised memory wait counter, a HALT opcode, a start/done handshake and a retired-instruction counter.
- Sits between the instruction ROM/PC and the datapath (reg file, ALU, data memory).

Parameters:
ALUW, 4, width of ALUOp output; opcode-derived values zero-extended to ALUW.
ALU_PASS, all-ones (ALUW bits), ALUOp value for pass-through (y=a); used by LW/SW/NOP/HALT and in idle states.
MEM_LAT, 1, data-memory cycles spent in MEM state (legal >=1).
CNTW, 16, width of retired-instruction counter.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin execution from IDLE
instr  in  4  opcode field from instruction ROM; sampled in FETCH
equal  in  1  ALU equality result; valid during EXEC
ir_load  out  1  instruction register load strobe
pc_en  out  1  PC advance strobe; asserted exactly once per retired instruction
Branch  out  1  PC takes branch target; only ever high together with pc_en
RegDst  out  1  register destination select
ALUSrc  out  1  1: immediate, 0: register
RegWrite  out  1  register-file write strobe
MemWrite  out  1  data-memory write strobe
MemtoReg  out  1  route memory data to reg-file write port
ALUOp  out  ALUW  ALU operation
flag_eq  out  1  stored compare flag
busy  out  1  high in every state except IDLE and HALT
done  out  1  high in HALT
instr_count  out  CNTW  retired instructions, saturating

Behaviour:
- Reset (async, reset_n=0):
  - Enter IDLE; clear ir_op, flag_eq, wait counter and instr_count.
  - All outputs 0 except ALUOp=ALU_PASS.
  - Reset mid-instruction aborts it; no strobe may glitch high during reset.
- Opcodes:
  - 0000 ADD, 0001 SLL, 0010 SLR, 0011 MOV, 0100 OR, 0101 XOR, 0110 AND, 0111 ADDi.
  - 1000 BNE, 1001 BEQ, 1010 MOVi, 1011 SW, 1100 LW, 1101 CMP.
  - 1110 NOP, 1111 HALT.
- Decoded static outputs (driven from ir_op, stable from DECODE through the instruction's last state; 0/ALU_PASS in IDLE/FETCH/HALT):
  - ALUOp = ir_op for 0000-1010 and 1101; ALU_PASS otherwise.
  - ALUSrc=1 for 0001, 0010, 0111, 1010, 1011, 1100.
  - RegDst=1 for 0000-0110.
  - MemtoReg=1 for LW in MEM and WB.
- State sequence:
  - IDLE: start=1 -> FETCH; else stay.
  - FETCH: ir_load=1; ir_op<=instr at clock edge -> DECODE.
  - DECODE -> EXEC.
  - EXEC:
    - CMP: flag_eq<=equal at edge.
    - BEQ: Branch=flag_eq. BNE: Branch=~flag_eq. Branch uses the stored flag, not live equal.
    - BEQ/BNE/CMP/NOP: pc_en=1 -> FETCH.
    - HALT -> HALT, no pc_en.
    - LW/SW -> MEM; load wait counter with MEM_LAT-1.
    - All others -> WB.
  - MEM: count down each cycle. On the cycle count==0 (final MEM cycle):
    - SW: MemWrite=1 and pc_en=1 -> FETCH. MemWrite is high exactly one cycle.
    - LW -> WB.
  - WB: RegWrite=1, pc_en=1 -> FETCH.
  - HALT: done=1. start=0 -> IDLE; start=1 holds HALT.
- Latency in cycles:
  - ALU/MOV/ADDi/MOVi: 4.
  - CMP/BEQ/BNE/NOP: 3.
  - SW: 3+MEM_LAT.
  - LW: 4+MEM_LAT.
  - HALT: 3 to done.
- instr_count: +1 on every cycle with pc_en=1; saturates at 2^CNTW-1 with no wrap. HALT is not counted.
- flag_eq persists across instructions until the next CMP or reset. A branch with no prior CMP uses the reset value 0.
- start is ignored outside IDLE and HALT.
- Mutual exclusion:
  - RegWrite and MemWrite are never high together.
  - pc_en is never high in FETCH/DECODE.

Test Plan:
- Reset, start=1 one cycle, instr=0000 -> ir_load in cycle 1, RegWrite+pc_en in cycle 4, RegDst=1, ALUOp=0000, instr_count=1.
- CMP with equal=1, then BNE, then BEQ -> flag_eq=1 after CMP. BNE EXEC: pc_en=1, Branch=0. BEQ EXEC: pc_en=1, Branch=1. instr_count=3.
- MEM_LAT=3: SW then LW -> SW retires after 6 cycles with one MemWrite pulse in the 6th. LW holds MemtoReg through MEM+WB, RegWrite in cycle 7 only.
- HALT -> done=1, busy=0, no pc_en, instr_count unchanged. start held 1 stays HALT; start=0 -> IDLE.
- reset_n low during LW MEM state -> immediate IDLE, flag_eq=0, instr_count=0, no MemtoReg/RegWrite afterward until start.
- CNTW=2: retire 5 NOPs -> instr_count reaches 3 and stays 3.
